c64_bus_arbiter: RTL and testbench
==================================

Name: c64_bus_arbiter

Overview:
- Generates the PAL system-cycle phase timing (phi1/phi2) from the video PLL clock.
- Shares the single C64 memory bus between the VIC6569 and the CPU.
- Drives BA/AEC-style handover, with the 3-cycle write-only warning window before the VIC steals phi2 slots for bad-line and sprite DMA.
- Sits beside VIC6569 in gm64 on the clkVid domain and feeds the memory mux and the CPU RDY input.

Parameters:
- PHI1_LEN, 12, clocks per phi1 half-cycle (VIC slot).
- PHI2_LEN, 13, clocks per phi2 half-cycle (CPU slot). Total cycle TOTAL = PHI1_LEN+PHI2_LEN = 25 clocks (about 0.992 MHz at 24.8 MHz).
- CYCLES_PER_LINE, 63, system cycles per raster line (PAL).

Ports:
- clk  input  1  video PLL clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- vic_dma_req  input  1  VIC needs phi2 slots (bad line or sprite DMA).
- cpu_req  input  1  CPU has a bus access pending this cycle.
- cpu_we  input  1  pending CPU access is a write.
- phi0  output  1  1 during phi2, 0 during phi1.
- phi1_stb  output  1  one-clock pulse on the first clock of phi1.
- phi2_stb  output  1  one-clock pulse on the first clock of phi2.
- line_stb  output  1  one-clock pulse on the first clock of cycle 0 of a line.
- cycle_x  output  6  system cycle index within the line, 0..CYCLES_PER_LINE-1.
- ba  output  1  bus available: 1 = CPU unrestricted.
- aec  output  1  1 = CPU owns the address/data bus.
- cpu_rdy  output  1  equals ba.
- grant_vic  output  1  VIC owns the memory bus this clock.
- grant_cpu  output  1  CPU access performed this clock.

Behaviour:
- pcnt: internal counter 0..TOTAL-1, +1 per clk, wraps TOTAL-1 -> 0. The "boundary edge" is the clock edge at which pcnt==TOTAL-1.
- Outputs decode combinationally from registered state; no extra latency.
  - phi0 = (pcnt >= PHI1_LEN).
  - phi1_stb = (pcnt==0).
  - phi2_stb = (pcnt==PHI1_LEN).
  - line_stb = (pcnt==0 && cycle_x==0).
- cycle_x: increments at each boundary edge; wraps CYCLES_PER_LINE-1 -> 0.
- FSM states RUN, WARN, STEAL, plus 2-bit warn_cnt. Updated only at boundary edges, using vic_dma_req sampled at that edge; vic_dma_req is ignored at other edges.
  - RUN: if vic_dma_req -> WARN, warn_cnt=0.
  - WARN: if !vic_dma_req -> RUN (abort). Else if warn_cnt==2 -> STEAL. Else warn_cnt+1. Uninterrupted WARN therefore lasts exactly 3 system cycles.
  - STEAL: if !vic_dma_req -> RUN; otherwise stay.
- Derived signals:
  - ba = (state==RUN); cpu_rdy = ba.
  - aec = phi0 && state!=STEAL.
  - grant_vic = !phi0 || state==STEAL.
  - grant_cpu = aec && cpu_req && (ba || cpu_we). During WARN, CPU writes proceed and reads are withheld (stall).
- grant_vic and grant_cpu are never both 1.
- Reset: pcnt=0, cycle_x=0, state=RUN, warn_cnt=0. Immediately after reset: phi0=0, phi1_stb=1, line_stb=1, phi2_stb=0, ba=1, cpu_rdy=1, aec=0, grant_vic=1, grant_cpu=0.
- Reset asserted mid-cycle or mid-STEAL/WARN: the next clock shows reset values, with no partial grant.
- vic_dma_req toggling within a cycle has no effect; only the boundary sample counts.
- Release from STEAL: ba=1 from the next phi1, and the CPU regains that cycle's phi2.

Test Plan:
- Reset, then 60 clocks idle -> phi1_stb at pcnt 0 (clocks 0, 25, 50); phi2_stb at clocks 12, 37; phi0 high clocks 12..24; ba=1 throughout; grant_vic=1 clocks 0..11.
- Free run 63*25 clocks -> cycle_x counts 0..62 then 0; line_stb exactly once per 1575 clocks; cycle_x never reaches 63.
- vic_dma_req=1 from cycle 5, cpu_req=1, cpu_we=1 -> ba=0 from cycle 6; grant_cpu in phi2 of cycles 6, 7, 8; aec=0 and grant_cpu=0 in cycle 9 onward.
- Same as the previous scenario with cpu_we=0 -> grant_cpu=0 in cycles 6..8 (read stall), cpu_rdy=0.
- vic_dma_req held 1 for 2 cycles then 0 -> WARN aborted: ba returns to 1 at next phi1; STEAL never entered; aec never drops during phi2.
- Enter STEAL, assert reset at pcnt=17 -> next clock pcnt=0, cycle_x=0, ba=1, grant_cpu=0; normal timing resumes.

Source files
------------

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - PAL phi1/phi2 timing and VIC/CPU memory bus arbitration
module c64_bus_arbiter #(
  parameter int PHI1_LEN        = 12,
  parameter int PHI2_LEN        = 13,
  parameter int CYCLES_PER_LINE = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vic_dma_req,
  input  logic       cpu_req,
  input  logic       cpu_we,
  output logic       phi0,
  output logic       phi1_stb,
  output logic       phi2_stb,
  output logic       line_stb,
  output logic [5:0] cycle_x,
  output logic       ba,
  output logic       aec,
  output logic       cpu_rdy,
  output logic       grant_vic,
  output logic       grant_cpu
);

  localparam int TOTAL = PHI1_LEN + PHI2_LEN;
  localparam int PW    = $clog2(TOTAL);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WARN  = 2'd1;
  localparam logic [1:0] ST_STEAL = 2'd2;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [5:0]    cycle_x_q, cycle_x_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    warn_cnt_q, warn_cnt_d;
  logic          boundary;

  // The last clock of a system cycle is the only point where line position and ownership move.
  assign boundary = (pcnt_q == PW'(TOTAL - 1));

  // Next-state: phase counter, line cycle counter and the BA warning/steal sequence.
  always_comb begin
    pcnt_d     = pcnt_q + PW'(1);
    cycle_x_d  = cycle_x_q;
    state_d    = state_q;
    warn_cnt_d = warn_cnt_q;
    if (boundary) begin
      pcnt_d = '0;
      if (cycle_x_q == 6'(CYCLES_PER_LINE - 1)) begin
        cycle_x_d = '0;
      end else begin
        cycle_x_d = cycle_x_q + 6'd1;
      end
      case (state_q)
        ST_RUN: begin
          if (vic_dma_req) begin
            state_d    = ST_WARN;
            warn_cnt_d = 2'd0;
          end
        end
        ST_WARN: begin
          if (!vic_dma_req) begin
            state_d = ST_RUN;
          end else if (warn_cnt_q == 2'd2) begin
            state_d = ST_STEAL;
          end else begin
            warn_cnt_d = warn_cnt_q + 2'd1;
          end
        end
        ST_STEAL: begin
          if (!vic_dma_req) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State registers with synchronous reset back to the start of a line, CPU unrestricted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q     <= '0;
      cycle_x_q  <= '0;
      state_q    <= ST_RUN;
      warn_cnt_q <= '0;
    end else begin
      pcnt_q     <= pcnt_d;
      cycle_x_q  <= cycle_x_d;
      state_q    <= state_d;
      warn_cnt_q <= warn_cnt_d;
    end
  end

  assign phi0     = (pcnt_q >= PW'(PHI1_LEN));
  assign phi1_stb = (pcnt_q == '0);
  assign phi2_stb = (pcnt_q == PW'(PHI1_LEN));
  assign line_stb = (pcnt_q == '0) && (cycle_x_q == '0);
  assign cycle_x  = cycle_x_q;

  // During WARN the CPU keeps its phi2 slot for writes only; reads stall on RDY.
  assign ba        = (state_q == ST_RUN);
  assign cpu_rdy   = ba;
  assign aec       = phi0 && (state_q != ST_STEAL);
  assign grant_vic = !phi0 || (state_q == ST_STEAL);
  assign grant_cpu = aec && cpu_req && (ba || cpu_we);

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - randomized self-checking bench for c64_bus_arbiter
module tb_c64_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vic_dma_req = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic       phi0, phi1_stb, phi2_stb, line_stb;
  logic [5:0] cycle_x;
  logic       ba, aec, cpu_rdy, grant_vic, grant_cpu;

  int errs = 0;
  int checks = 0;

  // Reference: time position within line plus count of consecutive boundary samples with DMA requested.
  int m_p = 0;
  int m_cyc = 0;
  int m_run = 0;

  int line_cnt = 0;
  int gcpu_cnt = 0;
  int aec_phi2_low = 0;
  logic cyc_req = 1'b0;

  c64_bus_arbiter dut (
    .clk(clk), .reset(reset), .vic_dma_req(vic_dma_req), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .phi0(phi0), .phi1_stb(phi1_stb), .phi2_stb(phi2_stb), .line_stb(line_stb),
    .cycle_x(cycle_x), .ba(ba), .aec(aec), .cpu_rdy(cpu_rdy),
    .grant_vic(grant_vic), .grant_cpu(grant_cpu)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d pcnt %0d)", tag, got, exp, m_cyc, m_p);
    end
  endtask

  // Compare every output against the reference position and DMA run length.
  task automatic compare_all();
    logic e_phi0, e_run, e_steal, e_aec;
    e_phi0  = (m_p >= 12);
    e_run   = (m_run == 0);
    e_steal = (m_run >= 4);
    e_aec   = e_phi0 && !e_steal;
    check_eq("phi0", phi0, e_phi0);
    check_eq("phi1_stb", phi1_stb, m_p == 0);
    check_eq("phi2_stb", phi2_stb, m_p == 12);
    check_eq("line_stb", line_stb, (m_p == 0) && (m_cyc == 0));
    check_eq("cycle_x", cycle_x, m_cyc);
    check_eq("ba", ba, e_run);
    check_eq("cpu_rdy", cpu_rdy, e_run);
    check_eq("aec", aec, e_aec);
    check_eq("grant_vic", grant_vic, !e_phi0 || e_steal);
    check_eq("grant_cpu", grant_cpu, e_aec && cpu_req && (e_run || cpu_we));
    check_eq("grant_excl", grant_vic && grant_cpu, 1'b0);
    if (line_stb) line_cnt++;
    if (grant_cpu) gcpu_cnt++;
    if (phi0 && !aec) aec_phi2_low++;
  endtask

  // One clock: edge, advance the reference with the inputs seen at that edge, then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_p = 0; m_cyc = 0; m_run = 0;
    end else begin
      if (m_p == 24) begin
        m_run = vic_dma_req ? ((m_run < 4) ? m_run + 1 : 4) : 0;
        m_cyc = (m_cyc + 1) % 63;
      end
      m_p = (m_p + 1) % 25;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input int cyc);
    int guard = 0;
    while (!(m_cyc == cyc && m_p == 0) && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("run_to_bound", guard < 2000, 1'b1);
  endtask

  task automatic dma_scenario(input logic we, input int hold_cycles, input string tag);
    run_to(5);
    vic_dma_req = 1'b1; cpu_req = 1'b1; cpu_we = we;
    gcpu_cnt = 0;
    repeat (hold_cycles * 25) step();
    vic_dma_req = 1'b0;
    repeat (2 * 25) step();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    check_eq("rst_ba", ba, 1'b1);
    check_eq("rst_line", line_stb, 1'b1);
    reset = 1'b0;
    repeat (60) step();

    // One full line with no DMA: exactly one line strobe.
    line_cnt = 0;
    repeat (63 * 25) step();
    check_eq("line_once", line_cnt, 1);

    // Write access keeps phi2 during three warning cycles, then loses the bus.
    dma_scenario(1'b1, 6, "wr");
    check_eq("wr_grants", gcpu_cnt, 3 * 13 + 2 * 13);

    // Read access stalls throughout the warning window.
    dma_scenario(1'b0, 6, "rd");
    check_eq("rd_grants", gcpu_cnt, 1 * 13 + 13);

    // Two-cycle request aborts the warning without ever dropping AEC in phi2.
    aec_phi2_low = 0;
    dma_scenario(1'b1, 2, "abort");
    check_eq("abort_aec", aec_phi2_low, 0);

    // Enter STEAL, then reset in the middle of phi2.
    run_to(10);
    vic_dma_req = 1'b1;
    repeat (5 * 25) step();
    while (m_p != 17) step();
    check_eq("steal_before_rst", aec, 1'b0);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1;
    step();
    check_eq("rst_cyc", cycle_x, 0);
    check_eq("rst_gcpu", grant_cpu, 1'b0);
    reset = 1'b0; vic_dma_req = 1'b0;
    repeat (50) step();

    // Random traffic: per-cycle DMA intent with mid-cycle glitches, random CPU requests, rare resets.
    for (int i = 0; i < 20000; i++) begin
      if (m_p == 0 && $urandom_range(0, 5) == 0) cyc_req = ~cyc_req;
      vic_dma_req = (m_p == 24) ? cyc_req : 1'($urandom);
      cpu_req = 1'($urandom);
      cpu_we = 1'($urandom);
      reset = ($urandom_range(0, 2999) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
